// File: rtl/lfsr_card_draw.sv
// Fibonacci LFSR with a req/draw handshake returning values in 1..MAX_VAL by rejection sampling.
// Optional REPEAT_REJECT_EN: also reject a candidate equal to the previous draw.
module lfsr_card_draw #(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   TAPS      = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0]   SEED      = WIDTH'(8'hA5),
   parameter int                 OUT_W     = 4,
   parameter int                 MAX_VAL   = 13,
   parameter int                 MAX_TRIES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             req,
   output logic             busy,
   output logic             draw_valid,
   output logic [OUT_W-1:0] draw_val,
   output logic [WIDTH-1:0] out
);

   localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   typedef enum logic {IDLE, SEARCH} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] lfsr, lfsr_nxt;
   logic [TW-1:0]    tries, tries_nxt;
   logic [OUT_W-1:0] cand, fire_val;
   logic             in_range, cand_ok, last_try, fire, advance;

   assign lfsr_nxt = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
   assign cand     = lfsr[OUT_W-1:0];
   assign in_range = (cand != '0) && (cand <= OUT_W'(MAX_VAL));
   assign last_try = (tries == TW'(MAX_TRIES - 1));
   assign out      = lfsr;

`ifdef REPEAT_REJECT_EN
   assign cand_ok = in_range && (cand != draw_val);
`else
   assign cand_ok = in_range;
`endif

   // state register plus the datapath registers it qualifies
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lfsr       <= SEED;
         tries      <= '0;
         draw_valid <= 1'b0;
         draw_val   <= '0;
      end else begin
         state      <= state_nxt;
         tries      <= tries_nxt;
         draw_valid <= fire;
         if (fire)
            draw_val <= fire_val;
         // a load wins over advancing, so the current cand is still judged this edge
         if (seed_load)
            lfsr <= (seed_in == '0) ? SEED : seed_in;
         else if (advance)
            lfsr <= lfsr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tries_nxt = tries;
      fire      = 1'b0;
      fire_val  = '0;
      case (state)
         IDLE: begin
            if (req) begin
               state_nxt = SEARCH;
               tries_nxt = '0;
            end
         end
         SEARCH: begin
            if (cand_ok) begin
               fire      = 1'b1;
               fire_val  = cand;
               state_nxt = IDLE;
            end else if (last_try) begin
               fire      = 1'b1;
               fire_val  = OUT_W'(1);
               state_nxt = IDLE;
            end else begin
               tries_nxt = tries + TW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state == SEARCH);
      advance = (state == SEARCH) || enable;
   end

endmodule

// File: tb/tb_lfsr_card_draw.sv
// Self-checking bench for lfsr_card_draw: directed cases plus randomized draws against a
// behavioural draw model. A second instance covers the fallback path (MAX_VAL=1, MAX_TRIES=2).
module tb_lfsr_card_draw;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, enable, seed_load, req, busy, draw_valid;
   logic [7:0] seed_in, out;
   logic [3:0] draw_val;

   logic       b_rst, b_enable, b_seed_load, b_req, b_busy, b_draw_valid;
   logic [7:0] b_seed_in, b_out;
   logic [3:0] b_draw_val;

   int n_chk  = 0;
   int n_fail = 0;

   lfsr_card_draw dut (
      .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
      .req(req), .busy(busy), .draw_valid(draw_valid), .draw_val(draw_val), .out(out)
   );

   lfsr_card_draw #(.MAX_VAL(1), .MAX_TRIES(2)) dut6 (
      .clk(clk), .rst(b_rst), .enable(b_enable), .seed_load(b_seed_load), .seed_in(b_seed_in),
      .req(b_req), .busy(b_busy), .draw_valid(b_draw_valid), .draw_val(b_draw_val), .out(b_out)
   );

   // x^8+x^6+x^5+x^4+1: feedback is the parity of the tapped bits, shifted in at the bottom
   function automatic logic [7:0] step(input logic [7:0] r);
      int ones = 0;
      for (int i = 0; i < 8; i++)
         if (8'hB8 & (8'd1 << i) & r) ones++;
      return {r[6:0], 1'(ones % 2)};
   endfunction

   // walk candidates until one is legal or the tries run out; n = evaluations used
   function automatic void model_draw(input logic [7:0] r0, input logic [3:0] last,
                                      input int maxv, input int maxt,
                                      output logic [3:0] val, output int n, output logic [7:0] rf);
      logic [7:0] r = r0;
      for (int t = 0; t < maxt; t++) begin
         int  c  = int'(r[3:0]);
         bit  ok = (c >= 1) && (c <= maxv);
`ifdef REPEAT_REJECT_EN
         if (c == int'(last)) ok = 1'b0;
`endif
         r = step(r);
         if (ok) begin
            val = 4'(c); n = t + 1; rf = r;
            return;
         end
      end
      val = 4'd1; n = maxt; rf = r;
   endfunction

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; tick; rst = 1'b0;
   endtask

   // req for one edge, then wait (bounded) for the pulse; lat counts edges from req edge
   task automatic run_draw(input bit rand_en, output logic [3:0] val, output int lat, output bit to);
      enable = 1'b0; req = 1'b1; tick; req = 1'b0; lat = 1;
      while (!draw_valid && lat < 200) begin
         if (rand_en) enable = 1'($urandom_range(0, 1));
         tick; lat++;
      end
      enable = 1'b0;
      to  = !draw_valid;
      val = draw_val;
   endtask

   task automatic test_reset;
      rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = 8'h00; req = 1'b0;
      tick; rst = 1'b0;
      n_chk++; if ({busy, draw_valid, draw_val, out} !== {1'b0, 1'b0, 4'h0, 8'hA5}) begin
         n_fail++; $display("FAIL reset: busy=%b valid=%b val=%h out=%h, want 0 0 0 a5", busy, draw_valid, draw_val, out);
      end
   endtask

   task automatic test_free_run;
      logic [7:0] exp_seq [3] = '{8'h4A, 8'h95, 8'h2A};
      do_reset; enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_chk++; if (out !== exp_seq[i]) begin
            n_fail++; $display("FAIL free_run[%0d]: out=%h want %h", i, out, exp_seq[i]);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_single_draw;
      do_reset;
      req = 1'b1; tick; req = 1'b0;
      n_chk++; if ({busy, draw_valid} !== 2'b10) begin
         n_fail++; $display("FAIL draw1_busy: busy=%b valid=%b want 1 0", busy, draw_valid);
      end
      tick;
      n_chk++; if ({busy, draw_valid, draw_val, out} !== {1'b0, 1'b1, 4'd5, 8'h4A}) begin
         n_fail++; $display("FAIL draw1: busy=%b valid=%b val=%0d out=%h want 0 1 5 4a", busy, draw_valid, draw_val, out);
      end
      tick;
      n_chk++; if ({draw_valid, draw_val} !== {1'b0, 4'd5}) begin
         n_fail++; $display("FAIL draw1_hold: valid=%b val=%0d want 0 5", draw_valid, draw_val);
      end
      req = 1'b1; tick; req = 1'b0; tick;
      n_chk++; if ({draw_valid, draw_val, out} !== {1'b1, 4'd10, 8'h95}) begin
         n_fail++; $display("FAIL draw2: valid=%b val=%0d out=%h want 1 10 95", draw_valid, draw_val, out);
      end
   endtask

   task automatic test_rejection;
      logic [7:0] regs [4] = '{8'h0F, 8'h1F, 8'h3E, 8'h7D};
      seed_in = 8'h0F; seed_load = 1'b1; tick; seed_load = 1'b0;
      req = 1'b1; tick; req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_chk++; if ({busy, draw_valid, out} !== {1'b1, 1'b0, regs[i]}) begin
            n_fail++; $display("FAIL reject[%0d]: busy=%b valid=%b out=%h want 1 0 %h", i, busy, draw_valid, out, regs[i]);
         end
         tick;
      end
      n_chk++; if ({busy, draw_valid, draw_val, out} !== {1'b0, 1'b1, 4'd13, 8'hFB}) begin
         n_fail++; $display("FAIL reject_accept: busy=%b valid=%b val=%0d out=%h want 0 1 13 fb", busy, draw_valid, draw_val, out);
      end
   endtask

   task automatic test_seed_zero_and_abort;
      seed_in = 8'h00; seed_load = 1'b1; tick; seed_load = 1'b0;
      n_chk++; if (out !== 8'hA5) begin
         n_fail++; $display("FAIL seed_zero: out=%h want a5", out);
      end
      seed_in = 8'h0F; seed_load = 1'b1; tick; seed_load = 1'b0;
      req = 1'b1; tick; req = 1'b0; tick;
      rst = 1'b1; tick; rst = 1'b0;
      n_chk++; if ({busy, draw_valid, draw_val, out} !== {1'b0, 1'b0, 4'd0, 8'hA5}) begin
         n_fail++; $display("FAIL abort: busy=%b valid=%b val=%0d out=%h want 0 0 0 a5", busy, draw_valid, draw_val, out);
      end
      for (int i = 0; i < 4; i++) begin
         tick;
         n_chk++; if ({busy, draw_valid} !== 2'b00) begin
            n_fail++; $display("FAIL abort_quiet[%0d]: busy=%b valid=%b want 0 0", i, busy, draw_valid);
         end
      end
   endtask

   task automatic test_seed_in_search;
      do_reset;
      seed_in = 8'h0F; seed_load = 1'b1; tick; seed_load = 1'b0;
      req = 1'b1; tick; req = 1'b0;
      seed_in = 8'h23; seed_load = 1'b1; tick; seed_load = 1'b0;
      n_chk++; if ({busy, out} !== {1'b1, 8'h23}) begin
         n_fail++; $display("FAIL seed_search_load: busy=%b out=%h want 1 23", busy, out);
      end
      tick;
      n_chk++; if ({draw_valid, draw_val, out} !== {1'b1, 4'd3, 8'h47}) begin
         n_fail++; $display("FAIL seed_search_draw: valid=%b val=%0d out=%h want 1 3 47", draw_valid, draw_val, out);
      end
   endtask

   task automatic test_repeat;
      logic [3:0] v; int lat; bit to;
      logic [3:0] exp_v; logic [7:0] exp_o; int exp_l;
`ifdef REPEAT_REJECT_EN
      exp_v = 4'd10; exp_o = 8'h14; exp_l = 3;
`else
      exp_v = 4'd5;  exp_o = 8'h8A; exp_l = 2;
`endif
      do_reset;
      run_draw(1'b0, v, lat, to);
      seed_in = 8'h45; seed_load = 1'b1; tick; seed_load = 1'b0;
      run_draw(1'b0, v, lat, to);
      n_chk++; if (to || v !== exp_v || lat != exp_l || out !== exp_o) begin
         n_fail++; $display("FAIL repeat: to=%b val=%0d lat=%0d out=%h want 0 %0d %0d %h", to, v, lat, out, exp_v, exp_l, exp_o);
      end
   endtask

   task automatic test_back_to_back;
      do_reset;
      req = 1'b1;
      tick; tick;
      n_chk++; if ({draw_valid, draw_val} !== {1'b1, 4'd5}) begin
         n_fail++; $display("FAIL b2b_first: valid=%b val=%0d want 1 5", draw_valid, draw_val);
      end
      tick;
      n_chk++; if ({busy, draw_valid} !== 2'b10) begin
         n_fail++; $display("FAIL b2b_accept: busy=%b valid=%b want 1 0", busy, draw_valid);
      end
      tick; req = 1'b0;
      n_chk++; if ({draw_valid, draw_val, out} !== {1'b1, 4'd10, 8'h95}) begin
         n_fail++; $display("FAIL b2b_second: valid=%b val=%0d out=%h want 1 10 95", draw_valid, draw_val, out);
      end
      tick;
      n_chk++; if ({busy, draw_valid} !== 2'b00) begin
         n_fail++; $display("FAIL b2b_idle: busy=%b valid=%b want 0 0", busy, draw_valid);
      end
   endtask

   task automatic test_fallback;
      int lat = 0;
      b_rst = 1'b1; b_enable = 1'b0; b_seed_load = 1'b0; b_seed_in = 8'h00; b_req = 1'b0;
      tick; b_rst = 1'b0;
      b_seed_in = 8'h0F; b_seed_load = 1'b1; tick; b_seed_load = 1'b0;
      // req stays high through the first SEARCH cycle; it must not queue a second draw
      b_req = 1'b1; tick; lat++; tick; lat++; b_req = 1'b0;
      while (!b_draw_valid && lat < 50) begin tick; lat++; end
      n_chk++; if ({b_draw_valid, b_draw_val, b_out} !== {1'b1, 4'd1, 8'h3E} || lat != 3) begin
         n_fail++; $display("FAIL fallback: valid=%b val=%0d out=%h lat=%0d want 1 1 3e 3", b_draw_valid, b_draw_val, b_out, lat);
      end
      for (int i = 0; i < 4; i++) begin
         tick;
         n_chk++; if ({b_busy, b_draw_valid} !== 2'b00) begin
            n_fail++; $display("FAIL fallback_noqueue[%0d]: busy=%b valid=%b want 0 0", i, b_busy, b_draw_valid);
         end
      end
   endtask

   task automatic test_random;
      logic [7:0] m_reg, e_reg, s;
      logic [3:0] m_last, e_val, v;
      int e_n, lat; bit to;
      do_reset; m_reg = 8'hA5; m_last = 4'd0;
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            seed_in = s; seed_load = 1'b1; tick; seed_load = 1'b0;
            m_reg = (s == 8'h00) ? 8'hA5 : s;
         end
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            enable = 1'b1; tick; m_reg = step(m_reg);
         end
         enable = 1'b0;
         model_draw(m_reg, m_last, 13, 32, e_val, e_n, e_reg);
         run_draw(1'b1, v, lat, to);
         n_chk++; if (to || v !== e_val || lat != e_n + 1 || out !== e_reg) begin
            n_fail++; $display("FAIL random[%0d]: to=%b val=%0d lat=%0d out=%h want 0 %0d %0d %h", it, to, v, lat, out, e_val, e_n + 1, e_reg);
         end
         m_reg = e_reg; m_last = e_val;
      end
   endtask

   initial begin
      b_rst = 1'b1; b_enable = 1'b0; b_seed_load = 1'b0; b_seed_in = 8'h00; b_req = 1'b0;
      test_reset;
      test_free_run;
      test_single_draw;
      test_rejection;
      test_seed_zero_and_abort;
      test_seed_in_search;
      test_repeat;
      test_back_to_back;
      test_fallback;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
